// File: rtl/button_conditioner.sv
// Multi-channel input conditioner: per-channel flop synchronizer followed by a
// debounce filter producing a stable level plus registered rise/fall strobes.

module button_conditioner_lane #(
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_sync,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] r_chain;
    logic [CW-1:0]     r_cnt;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;

    logic w_sync;
    logic w_diff;
    logic w_done;

    assign w_sync = r_chain[STAGES-1];
    assign w_diff = w_sync ^ r_level;
    // Accept the new value once it has disagreed for DEBOUNCE_CYCLES samples.
    assign w_done = w_diff && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_din};
            r_rise  <= w_done & w_sync;
            r_fall  <= w_done & ~w_sync;
            if (!w_diff || w_done)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_done)
                r_level <= w_sync;
        end
    end

    assign o_sync  = w_sync;
    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

module button_conditioner #(
    parameter int WIDTH           = 4,
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    // Channels share nothing but clock and reset.
    button_conditioner_lane #(
        .STAGES         (STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane [WIDTH-1:0] (
        .clk    (clk),
        .rst    (rst),
        .i_din  (din),
        .o_sync (sync),
        .o_level(level),
        .o_rise (rise),
        .o_fall (fall)
    );
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two configurations (2/4 and 3/1) driven with
// directed and random stimulus, checked against a sample-window reference model.

module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] din_a = 4'b0;
    logic [3:0] din_c = 4'b0;
    logic [3:0] sync_a, level_a, rise_a, fall_a;
    logic [3:0] sync_c, level_c, rise_c, fall_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_conditioner #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .din(din_a),
        .sync(sync_a), .level(level_a), .rise(rise_a), .fall(fall_a)
    );

    button_conditioner #(.WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(1)) dut_c (
        .clk(clk), .rst(rst), .din(din_c),
        .sync(sync_c), .level(level_c), .rise(rise_c), .fall(fall_c)
    );

    // Reference: sync is din seen STAGES edges ago; level flips when the last
    // DEBOUNCE_CYCLES sync samples since reset all disagree with it.
    logic [3:0] m_dh [2][8];
    logic [3:0] m_sh [2][8];
    int         m_nv [2];
    logic [3:0] m_sync [2];
    logic [3:0] m_lvl  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int k, input logic rv, input logic [3:0] dv,
                              input int s, input int d);
        bit all_d;
        if (rv) begin
            for (int i = 0; i < 8; i++) begin
                m_dh[k][i] = 4'b0;
                m_sh[k][i] = 4'b0;
            end
            m_nv[k]   = 0;
            m_sync[k] = 4'b0;
            m_lvl[k]  = 4'b0;
            m_rise[k] = 4'b0;
            m_fall[k] = 4'b0;
        end else begin
            for (int i = 7; i > 0; i--) m_sh[k][i] = m_sh[k][i-1];
            m_sh[k][0] = m_sync[k];
            if (m_nv[k] < 8) m_nv[k]++;
            m_rise[k] = 4'b0;
            m_fall[k] = 4'b0;
            for (int c = 0; c < 4; c++) begin
                all_d = (m_nv[k] >= d);
                for (int i = 0; i < d; i++)
                    if (m_sh[k][i][c] == m_lvl[k][c]) all_d = 1'b0;
                if (all_d) begin
                    m_lvl[k][c] = ~m_lvl[k][c];
                    if (m_lvl[k][c]) m_rise[k][c] = 1'b1;
                    else             m_fall[k][c] = 1'b1;
                end
            end
            for (int i = 7; i > 0; i--) m_dh[k][i] = m_dh[k][i-1];
            m_dh[k][0] = dv;
            m_sync[k] = m_dh[k][s-1];
        end
    endtask

    task automatic step(input logic rv, input logic [3:0] da, input logic [3:0] dc);
        @(negedge clk);
        rst   = rv;
        din_a = da;
        din_c = dc;
        @(posedge clk);
        model_edge(0, rv, da, 2, 4);
        model_edge(1, rv, dc, 3, 1);
        #1;
        chk("sync_a",  sync_a,  m_sync[0]);
        chk("level_a", level_a, m_lvl[0]);
        chk("rise_a",  rise_a,  m_rise[0]);
        chk("fall_a",  fall_a,  m_fall[0]);
        chk("sync_c",  sync_c,  m_sync[1]);
        chk("level_c", level_c, m_lvl[1]);
        chk("rise_c",  rise_c,  m_rise[1]);
        chk("fall_c",  fall_c,  m_fall[1]);
    endtask

    initial begin
        logic [3:0] da, dc;

        // Reset with all inputs high: everything reads zero.
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 4'b1111, 4'b1111);
            chk("rst_out_a", {sync_a, level_a, rise_a, fall_a}, 16'h0);
            chk("rst_out_c", {sync_c, level_c, rise_c, fall_c}, 16'h0);
        end

        // Clean rise on channel 0 (2/4) and channel 3 (3/1), fixed latencies.
        for (int n = 1; n <= 8; n++) begin
            step(1'b0, 4'b0001, 4'b1000);
            if (n == 1) chk("post_rst_out", {sync_a, level_a, rise_a, fall_a}, 16'h0);
            if (n == 1) chk("sync0_e1", sync_a[0], 1'b0);
            if (n == 2) chk("sync0_e2", sync_a[0], 1'b1);
            if (n == 5) chk("level0_e5", {level_a[0], rise_a[0]}, 2'b00);
            if (n == 6) chk("level0_e6", {level_a[0], rise_a[0]}, 2'b11);
            if (n == 7) chk("rise0_e7", rise_a, 4'b0000);
            chk("fall_quiet", fall_a, 4'b0000);
            if (n == 3) chk("level3_c_e3", level_c[3], 1'b0);
            if (n == 4) chk("level3_c_e4", {level_c[3], rise_c[3]}, 2'b11);
            if (n == 5) chk("rise3_c_e5", rise_c[3], 1'b0);
        end

        // 3-cycle pulse on channel 1 is rejected.
        for (int n = 0; n < 12; n++) begin
            step(1'b0, (n < 3) ? 4'b0011 : 4'b0001, 4'b1000);
            chk("glitch_lvl1", level_a[1], 1'b0);
            chk("glitch_rise1", rise_a[1], 1'b0);
        end

        // Random stimulus with occasional reset.
        da = 4'b0001;
        dc = 4'b1000;
        for (int n = 0; n < 2000; n++) begin
            logic rv;
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) da[c] = ~da[c];
                if ($urandom_range(0, 2) == 0) dc[c] = ~dc[c];
            end
            rv = ($urandom_range(0, 149) == 0);
            step(rv, da, dc);
            chk("rise_fall_excl_a", rise_a & fall_a, 4'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
